audio_timer_driver: RTL and testbench
=====================================

Name: audio_timer_driver

Overview:
- Hardware Avalon-MM master that programs and services the audio interval timer slave (16-bit data, 3-bit word address, fixed read latency 1, no waitrequest), so the audio datapath gets periodic ticks without Nios intervention.
- Loads the 32-bit period, starts the timer in continuous interrupt mode, clears each timeout, and counts ticks.
- Takes counter snapshots on request, and stops the timer on request.

Parameters:
- TICK_W, 16, width of tick_count (wraps modulo 2^TICK_W).
- CTRL_RUN, 4'h7, control word written at start: bit0 ITO, bit1 CONT, bit2 START.
- CTRL_STOP, 4'h8, control word written at stop: bit3 STOP; ITO/CONT are cleared.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  pulse: program period and start.
- cfg_stop  in  1  pulse: stop timer.
- cfg_period  in  32  period value, sampled on the accepted cfg_start.
- snap_req  in  1  pulse: capture counter snapshot.
- tm_address  out  3  timer word address.
- tm_chipselect  out  1  timer select.
- tm_write_n  out  1  active-low write.
- tm_writedata  out  16  write data.
- tm_readdata  in  16  read data, valid the cycle after the read address.
- tm_irq  in  1  timer interrupt, level.
- busy  out  1  FSM not in IDLE or RUN.
- running  out  1  timer started by this block and not yet stopped.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  serviced timeouts since the last start.
- snapshot  out  32  last captured counter value.
- snap_valid  out  1  one-cycle pulse when snapshot updates.

Behaviour:
- Reset (any time, including mid-access):
  - state=IDLE; tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
  - busy=0, running=0, tick=0, tick_count=0, snapshot=0, snap_valid=0.
  - No partial transfer is completed.
- All tm_* outputs are registered. Each access is exactly one cycle with tm_chipselect=1. Back-to-back accesses are permitted; there is no idle cycle between them.
- States: IDLE, WR_PL, WR_PH, WR_CTL, RUN, WR_CLR, WR_STOP, SN_WR, SN_RDL, SN_RDH, SN_CAP.
- Start sequence (from IDLE on cfg_start):
  - Latch cfg_period.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CTL: addr 1, data {12'h0, CTRL_RUN}.
  - Then RUN. running=1 and tick_count=0 take effect on the WR_CTL cycle.
  - Start latency: cfg_start in cycle N, writes in N+1..N+3, RUN from N+4.
- RUN priority per cycle: cfg_stop > tm_irq > snap_req.
  - cfg_stop: WR_STOP (addr 1, data {12'h0, CTRL_STOP}), then IDLE. running=0 at the WR_STOP cycle.
  - tm_irq=1: WR_CLR (addr 0, data 0).
    - tick=1 during the WR_CLR cycle; tick_count increments, wrapping all-ones -> 0.
    - Then RUN. The timer drops irq the cycle after WR_CLR, so one irq yields exactly one tick.
  - snap_req: snapshot sequence (see below).
- Snapshot sequence (accepted in IDLE or RUN):
  - SN_WR: write addr 4, data 0.
  - SN_RDL: read addr 4, write_n=1.
  - SN_RDH: read addr 5; tm_readdata is captured into snapshot[15:0] at the end of this cycle.
  - SN_CAP: bus idle; tm_readdata is captured into snapshot[31:16]; snap_valid=1.
  - Return to the originating state: RUN if running, else IDLE.
  - snap_valid occurs 4 cycles after the request cycle.
- Requests arriving in a busy state, and cfg_start while running, are dropped. cfg_stop in IDLE is dropped.
- tm_irq asserted during a snapshot or start sequence is not lost: it is level and is serviced on the first RUN cycle.
- tm_irq in IDLE is ignored.
- cfg_period=0 is written as-is; the timer then times out every cycle and the driver ticks at most every 2 cycles.

Test Plan:
1. Reset, cfg_start with cfg_period=32'h0001_86A0 -> writes (2,16'h86A0), (3,16'h0001), (1,16'h0007) on 3 consecutive cycles; running=1 at cycle 4; busy=0 in RUN.
2. In RUN, pulse tm_irq high until cleared, three times -> exactly 3 status writes (addr 0, data 0), 3 tick pulses, tick_count=3.
3. With TICK_W=2, 5 irqs -> tick_count sequence 1,2,3,0,1.
4. snap_req in RUN, slave returns 16'h1234 at addr 4 and 16'h0000 at addr 5 -> snapshot=32'h0000_1234, snap_valid 4 cycles after the request, state back to RUN.
5. cfg_stop and tm_irq in the same RUN cycle -> only the write (1,16'h0008), no tick, running=0, IDLE.
6. Assert reset_n=0 during WR_PH -> tm_chipselect=0 immediately; outputs at reset values; no WR_CTL after release.

Source files
------------

// File: rtl/audio_timer_driver.sv
// Avalon-MM master for the audio interval timer: loads the period, starts the
// timer in continuous interrupt mode, clears each timeout, counts ticks, takes snapshots.
module audio_timer_driver #(
  parameter int          TICK_W    = 16,
  parameter logic [3:0]  CTRL_RUN  = 4'h7,
  parameter logic [3:0]  CTRL_STOP = 4'h8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              snap_req,
  output logic [2:0]        tm_address,
  output logic              tm_chipselect,
  output logic              tm_write_n,
  output logic [15:0]       tm_writedata,
  input  logic [15:0]       tm_readdata,
  input  logic              tm_irq,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, WR_CLR, WR_STOP,
    SN_WR, SN_RDL, SN_RDH, SN_CAP
  } state_t;

  state_t      state, next_state;
  logic [15:0] period_hi;

  logic        bus_cs;
  logic        bus_write_n;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cfg_start)     next_state = WR_PL;
               else if (snap_req) next_state = SN_WR;
      WR_PL:   next_state = WR_PH;
      WR_PH:   next_state = WR_CTL;
      WR_CTL:  next_state = RUN;
      RUN:     if (cfg_stop)      next_state = WR_STOP;
               else if (tm_irq)   next_state = WR_CLR;
               else if (snap_req) next_state = SN_WR;
      WR_CLR:  next_state = RUN;
      WR_STOP: next_state = IDLE;
      SN_WR:   next_state = SN_RDL;
      SN_RDL:  next_state = SN_RDH;
      SN_RDH:  next_state = SN_CAP;
      SN_CAP:  next_state = running ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus fields are decoded from the next state and registered, so each access
  // lines up exactly with the state cycle that issues it.
  always_comb begin
    bus_cs      = 1'b1;
    bus_write_n = 1'b0;
    bus_addr    = 3'd0;
    bus_data    = 16'h0000;
    unique case (next_state)
      WR_PL:   begin bus_addr = 3'd2; bus_data = cfg_period[15:0]; end
      WR_PH:   begin bus_addr = 3'd3; bus_data = period_hi;        end
      WR_CTL:  begin bus_addr = 3'd1; bus_data = {12'h000, CTRL_RUN};  end
      WR_STOP: begin bus_addr = 3'd1; bus_data = {12'h000, CTRL_STOP}; end
      WR_CLR:  bus_addr = 3'd0;
      SN_WR:   bus_addr = 3'd4;
      SN_RDL:  begin bus_addr = 3'd4; bus_write_n = 1'b1; end
      SN_RDH:  begin bus_addr = 3'd5; bus_write_n = 1'b1; end
      default: begin bus_cs = 1'b0; bus_write_n = 1'b1; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      period_hi     <= 16'h0000;
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= 3'd0;
      tm_writedata  <= 16'h0000;
      running       <= 1'b0;
      tick          <= 1'b0;
      tick_count    <= '0;
      snapshot      <= 32'h0;
      snap_valid    <= 1'b0;
    end else begin
      state         <= next_state;
      tm_chipselect <= bus_cs;
      tm_write_n    <= bus_write_n;
      tm_address    <= bus_addr;
      tm_writedata  <= bus_data;
      tick          <= (next_state == WR_CLR);
      snap_valid    <= (next_state == SN_CAP);

      if (state == IDLE && cfg_start)
        period_hi <= cfg_period[31:16];

      if (next_state == WR_CTL) begin
        running    <= 1'b1;
        tick_count <= '0;
      end else if (next_state == WR_CLR) begin
        tick_count <= tick_count + 1'b1;
      end
      if (next_state == WR_STOP)
        running <= 1'b0;

      // Read latency is one cycle: addr 4 data arrives in SN_RDH, addr 5 in SN_CAP.
      if (state == SN_RDH) snapshot[15:0]  <= tm_readdata;
      if (state == SN_CAP) snapshot[31:16] <= tm_readdata;
    end
  end

  assign busy = (state != IDLE) && (state != RUN);

endmodule

// File: tb/tb_audio_timer_driver.sv
// Scoreboard bench for audio_timer_driver: a behavioural timer slave, expected
// bus accesses / ticks / snapshots queued with their cycle when stimulus is driven.
module tb_audio_timer_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, snap_req = 1'b0;
  logic [31:0] cfg_period = 32'h0;
  logic [2:0]  tm_address;
  logic        tm_chipselect, tm_write_n;
  logic [15:0] tm_writedata;
  logic [15:0] tm_readdata;
  logic        tm_irq;
  logic        busy, running, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snapshot;

  logic [2:0]  tm_address2;
  logic        tm_chipselect2, tm_write_n2;
  logic [15:0] tm_writedata2;
  logic        busy2, running2, tick2, snap_valid2;
  logic [1:0]  tick_count2;
  logic [31:0] snapshot2;

  logic        irq_set = 1'b0, irq_kill = 1'b0;
  logic [15:0] slave_lo = 16'h0, slave_hi = 16'h0;

  audio_timer_driver dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .snap_req(snap_req), .tm_address(tm_address),
    .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n), .tm_writedata(tm_writedata),
    .tm_readdata(tm_readdata), .tm_irq(tm_irq), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snapshot(snapshot), .snap_valid(snap_valid)
  );

  audio_timer_driver #(.TICK_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .snap_req(snap_req), .tm_address(tm_address2),
    .tm_chipselect(tm_chipselect2), .tm_write_n(tm_write_n2), .tm_writedata(tm_writedata2),
    .tm_readdata(tm_readdata), .tm_irq(tm_irq), .busy(busy2), .running(running2),
    .tick(tick2), .tick_count(tick_count2), .snapshot(snapshot2), .snap_valid(snap_valid2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: level irq held until a write to address 0; reads return after one cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_irq      <= 1'b0;
      tm_readdata <= 16'h0;
    end else begin
      tm_irq <= irq_set | (tm_irq & ~irq_kill &
                ~(tm_chipselect & ~tm_write_n & (tm_address == 3'd0)));
      if (tm_chipselect && tm_write_n)
        tm_readdata <= (tm_address == 3'd4) ? slave_lo :
                       (tm_address == 3'd5) ? slave_hi : 16'h0;
    end
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  addr;
    logic        wn;
    logic [15:0] data;
  } acc_t;
  typedef struct { int cyc; logic [15:0] c16; logic [1:0] c2; } tick_t;
  typedef struct { int cyc; logic [31:0] val; } snap_t;

  acc_t  acc_q[$];
  tick_t tick_q[$];
  snap_t snap_q[$];
  int    ticks_model = 0;
  bit    snap_pending = 0;
  logic [31:0] snap_exp = 32'h0;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (tm_chipselect) begin
        if (acc_q.size() == 0)
          check("bus_extra", {cyc, tm_address, tm_write_n, tm_writedata}, 64'h0);
        else begin
          acc_t e;
          e = acc_q.pop_front();
          check("bus_access", {cyc, tm_address, tm_write_n, tm_writedata}, e);
        end
      end
      if (tick) begin
        if (tick_q.size() == 0)
          check("tick_extra", {cyc, tick_count}, 64'h0);
        else begin
          tick_t t;
          t = tick_q.pop_front();
          check("tick", {cyc, tick_count}, {t.cyc, t.c16});
          check("tick_w2", tick_count2, t.c2);
        end
      end
      if (snap_pending) begin
        check("snapshot", snapshot, snap_exp);
        snap_pending = 0;
      end
      if (snap_valid) begin
        if (snap_q.size() == 0)
          check("snap_extra", cyc, 0);
        else begin
          snap_t s;
          s = snap_q.pop_front();
          check("snap_cycle", cyc, s.cyc);
          snap_exp     = s.val;
          snap_pending = 1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic acc_t mk(input int c, input logic [2:0] a, input logic wn, input logic [15:0] d);
    return '{cyc: c, addr: a, wn: wn, data: d};
  endfunction

  task automatic push_tick(input int c);
    tick_t t;
    ticks_model++;
    t.cyc = c;
    t.c16 = ticks_model[15:0];
    t.c2  = ticks_model[1:0];
    tick_q.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, tm_chipselect, 1'b0);
    check({tag, "_wn"}, tm_write_n, 1'b1);
    check({tag, "_addr"}, tm_address, 3'd0);
    check({tag, "_data"}, tm_writedata, 16'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_running"}, running, 1'b0);
    check({tag, "_tick"}, tick, 1'b0);
    check({tag, "_tick_count"}, tick_count, 16'h0);
    check({tag, "_snapshot"}, snapshot, 32'h0);
    check({tag, "_snap_valid"}, snap_valid, 1'b0);
  endtask

  task automatic do_start(input logic [31:0] p);
    int k;
    k = cyc;
    cfg_period = p;
    cfg_start  = 1'b1;
    acc_q.push_back(mk(k + 1, 3'd2, 1'b0, p[15:0]));
    acc_q.push_back(mk(k + 2, 3'd3, 1'b0, p[31:16]));
    acc_q.push_back(mk(k + 3, 3'd1, 1'b0, 16'h0007));
    ticks_model = 0;
    step(1);
    cfg_start = 1'b0;
    snap_req  = 1'b1;  // arrives while busy: must be dropped
    check("busy_start", busy, 1'b1);
    step(1);
    snap_req = 1'b0;
    step(1);
    check("running_on_ctl", running, 1'b1);
    step(1);
    check("running_in_run", running, 1'b1);
    check("busy_in_run", busy, 1'b0);
  endtask

  task automatic do_irq();
    int k;
    k = cyc;
    irq_set = 1'b1;
    acc_q.push_back(mk(k + 2, 3'd0, 1'b0, 16'h0));
    push_tick(k + 2);
    step(1);
    irq_set = 1'b0;
    step(3);
  endtask

  task automatic do_snap(input logic [15:0] lo, input logic [15:0] hi, input bit with_irq,
                         input bit exp_running);
    int k;
    k = cyc;
    slave_lo = lo;
    slave_hi = hi;
    snap_req = 1'b1;
    irq_set  = with_irq;
    acc_q.push_back(mk(k + 1, 3'd4, 1'b0, 16'h0));
    acc_q.push_back(mk(k + 2, 3'd4, 1'b1, 16'h0));
    acc_q.push_back(mk(k + 3, 3'd5, 1'b1, 16'h0));
    snap_q.push_back('{cyc: k + 4, val: {hi, lo}});
    if (with_irq) begin
      acc_q.push_back(mk(k + 6, 3'd0, 1'b0, 16'h0));
      push_tick(k + 6);
    end
    step(1);
    snap_req = 1'b0;
    irq_set  = 1'b0;
    step(1);
    check("busy_snap", busy, 1'b1);
    step(5);
    check("busy_after_snap", busy, 1'b0);
    check("running_after_snap", running, exp_running);
  endtask

  task automatic do_stop();
    int k;
    k = cyc;
    cfg_stop = 1'b1;
    acc_q.push_back(mk(k + 1, 3'd1, 1'b0, 16'h0008));
    step(1);
    cfg_stop = 1'b0;
    step(2);
    check("running_after_stop", running, 1'b0);
    check("busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    step(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step(2);

    // Snapshot from IDLE returns to IDLE; stop in IDLE is dropped.
    do_snap(16'hCAFE, 16'hBEEF, 1'b0, 1'b0);
    cfg_stop = 1'b1;
    step(1);
    cfg_stop = 1'b0;
    step(3);

    do_start(32'h0001_86A0);
    cfg_start  = 1'b1;  // start while running: dropped
    cfg_period = 32'hFFFF_FFFF;
    step(1);
    cfg_start = 1'b0;
    step(3);

    for (int i = 0; i < 5; i++) do_irq();

    do_snap(16'h1234, 16'h0000, 1'b0, 1'b1);
    do_snap(16'h5678, 16'h9ABC, 1'b1, 1'b1);

    // Stop and irq in the same RUN cycle: only the stop write, no tick.
    k = cyc;
    irq_set = 1'b1;
    step(1);
    irq_set  = 1'b0;
    cfg_stop = 1'b1;
    acc_q.push_back(mk(k + 2, 3'd1, 1'b0, 16'h0008));
    step(1);
    cfg_stop = 1'b0;
    check("running_stop_irq", running, 1'b0);
    step(1);
    check("busy_stop_irq", busy, 1'b0);
    step(3);
    irq_kill = 1'b1;
    step(1);
    irq_kill = 1'b0;
    step(2);

    // Zero period: irq held high continuously, serviced every other cycle.
    do_start(32'h0);
    k = cyc;
    irq_set = 1'b1;
    acc_q.push_back(mk(k + 2, 3'd0, 1'b0, 16'h0)); push_tick(k + 2);
    acc_q.push_back(mk(k + 4, 3'd0, 1'b0, 16'h0)); push_tick(k + 4);
    acc_q.push_back(mk(k + 6, 3'd0, 1'b0, 16'h0)); push_tick(k + 6);
    step(5);
    irq_set = 1'b0;
    step(4);
    do_stop();

    // Reset during WR_PH: bus drops at once, no WR_CTL afterwards.
    k = cyc;
    cfg_period = 32'hA5A5_5A5A;
    cfg_start  = 1'b1;
    acc_q.push_back(mk(k + 1, 3'd2, 1'b0, 16'h5A5A));
    acc_q.push_back(mk(k + 2, 3'd3, 1'b0, 16'hA5A5));
    step(1);
    cfg_start = 1'b0;
    step(1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(6);
    check("running_after_reset", running, 1'b0);

    check("acc_q_drained", acc_q.size(), 0);
    check("tick_q_drained", tick_q.size(), 0);
    check("snap_q_drained", snap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
